// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - one-hot opcode constants (OP_ADD, OP_SUB, OP_FLOG2, OP_SQRT)
//   - FSM state enum alu_state_e and the debug struct exposed by the top
//   - flog2(): priority encoder returning the index of the highest set bit
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_FLOG2 = 4'b0100;
    localparam logic [3:0] OP_SQRT  = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    // Observation struct: FSM state plus the sqrt engine activity flag.
    typedef struct packed {
        alu_state_e state;
        logic       sqrt_busy;
    } alu_dbg_t;

    // Widest operand the encoder handles; callers zero-extend into it.
    localparam int FLOG2_MAX_W = 64;

    // Index of the highest set bit among the low 'width' bits of v.
    // Returns 0 for v == 0; the caller flags that case separately.
    function automatic logic [6:0] flog2(input logic [FLOG2_MAX_W-1:0] v,
                                         input int width);
        logic [6:0] idx;
        idx = '0;
        for (int i = 0; i < FLOG2_MAX_W; i++) begin
            if (i < width && v[i]) idx = 7'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sqrt_iter.sv
// sqrt_iter: restoring digit-by-digit integer square root, one root bit
// per clock.
//   clk_i, rst_i : clock, synchronous active-high reset
//   start_i      : load a_i; the first iteration is folded into the load edge
//   a_i          : radicand (WIDTH bits)
//   busy_o       : iterations still pending
//   done_o       : one-cycle pulse; root_o is final while it is high
//   root_o       : floor(sqrt(a)), WIDTH/2 bits, held until the next start
module sqrt_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH/2-1:0] root_o
);

    localparam int HW = WIDTH / 2;
    // Before each shift the remainder is below 2^HW, so HW+2 bits hold the
    // shifted value (rem*4 + next digit pair) without overflow.
    localparam int RW = HW + 2;
    localparam int CW = $clog2(HW + 1);

    logic [WIDTH-1:0] a_sh_q;
    logic [RW-1:0]    rem_q;
    logic [HW-1:0]    root_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] src_a;
    logic [RW-1:0]    src_rem;
    logic [HW-1:0]    src_root;
    logic [RW-1:0]    shifted;
    logic [RW:0]      trial;
    logic             take;
    logic [RW-1:0]    next_rem;
    logic [HW-1:0]    next_root;
    logic [WIDTH-1:0] next_a;

    // One restoring step. On start the step runs on the fresh operand, so
    // the engine needs HW clock edges in total, the first being the load.
    always_comb begin
        src_a     = start_i ? a_i : a_sh_q;
        src_rem   = start_i ? '0  : rem_q;
        src_root  = start_i ? '0  : root_q;
        shifted   = {src_rem[RW-3:0], src_a[WIDTH-1 -: 2]};
        trial     = {1'b0, shifted} - {1'b0, src_root, 2'b01};
        take      = ~trial[RW];
        next_rem  = take ? trial[RW-1:0] : shifted;
        next_root = {src_root[HW-2:0], take};
        next_a    = {src_a[WIDTH-3:0], 2'b00};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_sh_q <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                a_sh_q <= next_a;
                rem_q  <= next_rem;
                root_q <= next_root;
                cnt_q  <= CW'(1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                a_sh_q <= next_a;
                rem_q  <= next_rem;
                root_q <= next_root;
                cnt_q  <= cnt_q + CW'(1);
                if (cnt_q == CW'(HW - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign root_o = root_q;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU executing one operation at a time.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   valid_i / ready_o  : request handshake (a_i, b_i, operation_i)
//   valid_o / ready_i  : result handshake (y_o, carry_o, err_o)
//   operation_i        : one-hot 0001 add, 0010 sub, 0100 flog2(a), 1000 sqrt(a)
//   dbg_o              : FSM state and sqrt engine activity
// WIDTH must be even, >= 4 and <= 64.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. ready_o is high only in IDLE and valid_o only in DONE, both
// decoded from the state register alone; while valid_o is high the result
// outputs do not change. The cycle that completes a result transfer never
// also accepts a request, giving at best one result per two cycles.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       operation_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] y_o,
    output logic             carry_o,
    output logic             err_o,
    output alu_dbg_t         dbg_o
);

    localparam int HW = WIDTH / 2;

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] y_q;
    logic             carry_q;
    logic             err_q;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] res_y;
    logic             res_c;
    logic             res_e;
    logic             accept;
    logic             is_sqrt;
    logic             sqrt_busy;
    logic             sqrt_done;
    logic [HW-1:0]    sqrt_root;

    assign accept  = (state_q == IDLE) && valid_i;
    assign is_sqrt = (operation_i == OP_SQRT);

    // Single-cycle datapath; sqrt is handled by the iterative engine.
    always_comb begin
        sum_w  = {1'b0, a_i} + {1'b0, b_i};
        diff_w = {1'b0, a_i} - {1'b0, b_i};
        res_y  = '0;
        res_c  = 1'b0;
        res_e  = 1'b0;
        case (operation_i)
            OP_ADD: begin
                res_y = sum_w[WIDTH-1:0];
                res_c = sum_w[WIDTH];
            end
            OP_SUB: begin
                res_y = diff_w[WIDTH-1:0];
                res_c = diff_w[WIDTH];
            end
            OP_FLOG2: begin
                res_y = WIDTH'(flog2(FLOG2_MAX_W'(a_i), WIDTH));
                res_e = (a_i == '0);
            end
            OP_SQRT: begin
                res_y = '0;
            end
            default: begin
                res_e = 1'b1;
            end
        endcase
    end

    sqrt_iter #(
        .WIDTH(WIDTH)
    ) u_sqrt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start_i(accept && is_sqrt),
        .a_i    (a_i),
        .busy_o (sqrt_busy),
        .done_o (sqrt_done),
        .root_o (sqrt_root)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_i) state_d = is_sqrt ? BUSY : DONE;
            BUSY:    if (sqrt_done) state_d = DONE;
            DONE:    if (ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            y_q     <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept && !is_sqrt) begin
                y_q     <= res_y;
                carry_q <= res_c;
                err_q   <= res_e;
            end else if (state_q == BUSY && sqrt_done) begin
                y_q     <= {{(WIDTH-HW){1'b0}}, sqrt_root};
                carry_q <= 1'b0;
                err_q   <= 1'b0;
            end
        end
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);
    assign y_o     = y_q;
    assign carry_o = carry_q;
    assign err_o   = err_q;
    assign dbg_o   = '{state: state_q, sqrt_busy: sqrt_busy};

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    import alu_pkg::*;

    // Scoreboard entry: {expected valid edge[15:0], y[15:0], carry, err}
    localparam int EW = 34;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic mon_en = 1'b0;

    logic [EW-1:0] exp_q8[$];
    logic [EW-1:0] exp_q16[$];
    logic          prev_v[2];
    logic          idle_chk[2];

    // WIDTH=8 instance signals
    logic        valid_i8 = 1'b0, ready_i8 = 1'b1;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [3:0]  op8 = '0;
    logic        ready_o8, valid_o8, c8, e8;
    logic [7:0]  y8;
    alu_dbg_t    dbg8;

    // WIDTH=16 instance signals
    logic        valid_i16 = 1'b0, ready_i16 = 1'b1;
    logic [15:0] a16 = '0, b16 = '0;
    logic [3:0]  op16 = '0;
    logic        ready_o16, valid_o16, c16, e16;
    logic [15:0] y16;
    alu_dbg_t    dbg16;

    alu_seq #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i8), .ready_o(ready_o8),
        .a_i(a8), .b_i(b8), .operation_i(op8), .valid_o(valid_o8),
        .ready_i(ready_i8), .y_o(y8), .carry_o(c8), .err_o(e8), .dbg_o(dbg8)
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i16), .ready_o(ready_o16),
        .a_i(a16), .b_i(b16), .operation_i(op16), .valid_o(valid_o16),
        .ready_i(ready_i16), .y_o(y16), .carry_o(c16), .err_o(e16), .dbg_o(dbg16)
    );

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic mon_step(input int d, input logic vo, input logic ro, input logic ri,
                            input logic [15:0] y, input logic c, input logic e);
        logic [EW-1:0] fr;
        int depth;
        depth = (d == 0) ? exp_q8.size() : exp_q16.size();
        if (idle_chk[d]) begin
            check($sformatf("dut%0d idle after handshake {valid_o,ready_o}", d), 32'({vo, ro}), 32'd1);
            idle_chk[d] = 1'b0;
        end
        if (vo) begin
            if (depth == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL dut%0d unexpected valid_o: got 1, required 0 (cycle %0d)", d, cyc);
            end else begin
                fr = (d == 0) ? exp_q8[0] : exp_q16[0];
                if (!prev_v[d]) check($sformatf("dut%0d valid_o edge", d), 32'(cyc), 32'(fr[33:18]));
                check($sformatf("dut%0d ready_o in DONE", d), 32'(ro), 32'd0);
                check($sformatf("dut%0d y_o", d), 32'(y), 32'(fr[17:2]));
                check($sformatf("dut%0d carry_o", d), 32'(c), 32'(fr[1]));
                check($sformatf("dut%0d err_o", d), 32'(e), 32'(fr[0]));
                if (ri) begin
                    if (d == 0) void'(exp_q8.pop_front());
                    else void'(exp_q16.pop_front());
                    idle_chk[d] = 1'b1;
                end
            end
        end else if (depth != 0) begin
            check($sformatf("dut%0d ready_o while in flight", d), 32'(ro), 32'd0);
        end
        prev_v[d] = vo;
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            mon_step(0, valid_o8, ready_o8, ready_i8, 16'(y8), c8, e8);
            mon_step(1, valid_o16, ready_o16, ready_i16, y16, c16, e16);
        end
    end

    // ---------------- driver tasks ----------------
    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic issue(input int d, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] y, input logic c,
                         input logic e, input int lat);
        int budget;
        budget = 0;
        while (!((d == 0) ? ready_o8 : ready_o16) && budget < 100) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (budget >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL dut%0d ready_o wait: got timeout, required ready_o=1", d);
            return;
        end
        if (d == 0) begin
            valid_i8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            valid_i16 = 1'b1; op16 = op; a16 = a; b16 = b;
        end
        @(posedge clk);
        #1;
        valid_i8  = 1'b0;
        valid_i16 = 1'b0;
        if (d == 0) exp_q8.push_back({16'(cyc + lat), y, c, e});
        else exp_q16.push_back({16'(cyc + lat), y, c, e});
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while ((exp_q8.size() != 0 || exp_q16.size() != 0) && budget < 200) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (budget >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain wait: got %0d/%0d pending, required 0/0", exp_q8.size(), exp_q16.size());
            exp_q8.delete();
            exp_q16.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        prev_v   = '{1'b0, 1'b0};
        idle_chk = '{1'b0, 1'b0};
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset valid_o8", 32'(valid_o8), 32'd0);
        check("reset ready_o8", 32'(ready_o8), 32'd1);
        check("reset y_o8", 32'(y8), 32'd0);
        check("reset carry/err8", 32'({c8, e8}), 32'd0);
        check("reset state8", 32'(dbg8.state), 32'(IDLE));
        check("reset valid_o16", 32'(valid_o16), 32'd0);
        check("reset ready_o16", 32'(ready_o16), 32'd1);
        check("reset y_o16", 32'(y16), 32'd0);
        check("reset state16", 32'(dbg16.state), 32'(IDLE));
        rst = 1'b0;
        mon_en = 1'b1;

        // WIDTH=8 single-cycle ops
        issue(0, OP_ADD,   16'd200, 16'd100, 16'd44,  1'b1, 1'b0, 0);
        issue(0, OP_SUB,   16'd5,   16'd7,   16'd254, 1'b1, 1'b0, 0);
        issue(0, OP_SUB,   16'd7,   16'd5,   16'd2,   1'b0, 1'b0, 0);
        issue(0, OP_ADD,   16'd10,  16'd20,  16'd30,  1'b0, 1'b0, 0);
        issue(0, OP_FLOG2, 16'd130, 16'd0,   16'd7,   1'b0, 1'b0, 0);
        issue(0, OP_FLOG2, 16'd1,   16'd0,   16'd0,   1'b0, 1'b0, 0);
        issue(0, OP_FLOG2, 16'd0,   16'd0,   16'd0,   1'b0, 1'b1, 0);

        // WIDTH=8 sqrt: valid after WIDTH/2 further edges
        issue(0, OP_SQRT, 16'd255, 16'd0, 16'd15, 1'b0, 1'b0, 4);
        issue(0, OP_SQRT, 16'd0,   16'd0, 16'd0,  1'b0, 1'b0, 4);
        issue(0, OP_SQRT, 16'd144, 16'd0, 16'd12, 1'b0, 1'b0, 4);
        issue(0, OP_SQRT, 16'd143, 16'd0, 16'd11, 1'b0, 1'b0, 4);
        wait_drain();

        // Illegal opcode under back-pressure, then another illegal opcode
        ready_i8 = 1'b0;
        issue(0, 4'b0000, 16'd9, 16'd9, 16'd0, 1'b0, 1'b1, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        ready_i8 = 1'b1;
        issue(0, 4'b0011, 16'd9, 16'd9, 16'd0, 1'b0, 1'b1, 0);
        wait_drain();

        // Reset during the second sqrt iteration aborts the operation
        issue(0, OP_SQRT, 16'd200, 16'd0, 16'd14, 1'b0, 1'b0, 4);
        rst = 1'b1;
        exp_q8.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort valid_o8", 32'(valid_o8), 32'd0);
        check("abort ready_o8", 32'(ready_o8), 32'd1);
        check("abort y_o8", 32'(y8), 32'd0);
        check("abort carry/err8", 32'({c8, e8}), 32'd0);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        issue(0, OP_ADD, 16'd1, 16'd1, 16'd2, 1'b0, 1'b0, 0);
        wait_drain();

        // WIDTH=16
        issue(1, OP_SQRT,  16'hFFFF, 16'd0,  16'd255,  1'b0, 1'b0, 8);
        issue(1, OP_ADD,   16'hFFFF, 16'd1,  16'd0,    1'b1, 1'b0, 0);
        issue(1, OP_FLOG2, 16'h8000, 16'd0,  16'd15,   1'b0, 1'b0, 0);
        issue(1, OP_SUB,   16'd0,    16'd1,  16'hFFFF, 1'b1, 1'b0, 0);
        issue(1, OP_SQRT,  16'd10000, 16'd0, 16'd100,  1'b0, 1'b0, 8);
        wait_drain();

        check("scoreboard8 drained", 32'(exp_q8.size()), 32'd0);
        check("scoreboard16 drained", 32'(exp_q16.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the combinational 8-bit ALU. It executes one operation at a time from the same one-hot opcode set: add, subtract, floor-log2 and floor-sqrt. Add, subtract and log2 finish in one cycle; sqrt runs as an iterative, multi-cycle engine. The block sits between an operand producer and a result consumer, each with a valid/ready handshake.

## Interface
- `WIDTH`, default 8: operand and result width; must be even and ≥ 4.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `valid_i`  in  1  operands and opcode valid.
- `ready_o`  out  1  block can accept a request.
- `a_i`  in  WIDTH  operand A.
- `b_i`  in  WIDTH  operand B; used by add/sub only.
- `operation_i`  in  4  one-hot opcode: 0001 add, 0010 sub, 0100 flog2(a), 1000 sqrt(a).
- `valid_o`  out  1  result valid.
- `ready_i`  in  1  consumer accepts the result.
- `y_o`  out  WIDTH  result.
- `carry_o`  out  1  add: carry-out; sub: borrow (a < b); otherwise 0.
- `err_o`  out  1  illegal opcode, or flog2 with a = 0.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - `ready_o` = 1.
  - On `valid_i` the request is accepted and operands are captured.
  - sqrt goes to BUSY. Every other opcode goes directly to DONE with its result registered.
- BUSY (sqrt only):
  - Restoring digit-by-digit sqrt, one result bit per cycle.
  - Runs WIDTH/2 iterations, then goes to DONE.
  - `ready_o` = 0.
- DONE:
  - `valid_o` = 1 and outputs are held stable.
  - `ready_o` = 0.
  - When `ready_i` = 1, returns to IDLE. No new request is accepted in that same cycle.
- Arithmetic:
  - add/sub wrap modulo 2^WIDTH. `carry_o` is bit WIDTH of the (WIDTH+1)-bit sum or difference.
  - flog2: index of the highest set bit of a.
  - sqrt: floor(sqrt(a)), zero-extended to WIDTH bits (upper WIDTH/2 bits are 0).
- Errors:
  - flog2 with a = 0: `y_o` = 0, `err_o` = 1.
  - `operation_i` not one-hot (including 0000): request is accepted, `y_o` = 0, `carry_o` = 0, `err_o` = 1, single-cycle path.
  - `err_o` is 0 for all legal results.
- Inputs are ignored outside IDLE. Operand changes during BUSY have no effect.

## Timing
- Reset: state goes to IDLE; `valid_o`, `y_o`, `carry_o`, `err_o`, the sqrt iteration counter and the remainder all become 0; `ready_o` = 1 in the cycle after reset.
- Reset mid-operation (BUSY or DONE) aborts the operation. The result is discarded and never presented.
- Request accepted at edge N:
  - add/sub/flog2/illegal: `valid_o` is high from cycle N+1.
  - sqrt: `valid_o` is high from cycle N+1+WIDTH/2. For WIDTH=8 that is N+5.
- Back-pressure: `valid_o`, `y_o`, `carry_o` and `err_o` are stable for as long as `ready_i` = 0.
- Throughput: at best one result per 2 cycles (single-cycle ops with `ready_i` tied high).
- `ready_o` is decoded from state only, with no combinational path from `valid_i` or `ready_i`.
- `valid_o` is decoded from state only, with no combinational path from `valid_i` or `ready_i`.

## Structure
- Package `alu_pkg` holds:
  - opcode localparams `OP_ADD`, `OP_SUB`, `OP_FLOG2`, `OP_SQRT`;
  - the state enum `alu_state_e` (`IDLE`/`BUSY`/`DONE`);
  - a `flog2` function parametrised by width (priority encoder).
- Sub-module `sqrt_iter` (parameter `WIDTH`):
  - Ports: `clk_i`, `rst_i`, `start_i`, `a_i` in; `busy_o`, `done_o` (one-cycle pulse), `root_o` (WIDTH/2 bits) out.
  - Holds the remainder, partial root and a counter of width $clog2(WIDTH/2+1).
- Top level holds the FSM, the add/sub/flog2 datapath and the output registers.

## Test plan
- WIDTH=8, add a=200, b=100 → `y_o`=44, `carry_o`=1, `err_o`=0; `valid_o` high exactly one cycle after acceptance.
- WIDTH=8, sub a=5, b=7 → `y_o`=254, `carry_o`=1. Then flog2 a=130 → `y_o`=7. Then flog2 a=0 → `y_o`=0, `err_o`=1.
- WIDTH=8, sqrt a=255 → `y_o`=15 with `valid_o` at N+5. Sqrt a=0 → 0; a=144 → 12; a=143 → 11. `ready_o` stays low throughout BUSY.
- Illegal opcodes 0000 and 0011, a=9, b=9 → `y_o`=0, `err_o`=1 after one cycle. `ready_i` held low for 3 cycles → outputs stable and `ready_o` stays 0; releasing `ready_i` → IDLE on the next cycle.
- Assert `rst_i` for one cycle during the 2nd sqrt iteration → all outputs 0, `ready_o`=1 the next cycle, no `valid_o` pulse. A following add 1+1 → `y_o`=2.
- WIDTH=16:
  - sqrt 65535 → 255 after 8 iterations.
  - add 65535+1 → `y_o`=0, `carry_o`=1.
  - flog2 0x8000 → 15.
